// File: rtl/ov_src_pkg.sv
// Shared types, CRC constants and helpers for the OV7670-style DVP pattern source.
package ov_src_pkg;

  typedef enum logic [1:0] {
    MODE_HRAMP   = 2'd0,
    MODE_VRAMP   = 2'd1,
    MODE_CHECK   = 2'd2,
    MODE_BYTECNT = 2'd3
  } mode_t;

  typedef enum logic [1:0] {FP, SYNC, BP, ACTV} region_t;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Region of a counter along one axis; regions follow each other as FP, SYNC, BP, ACTV.
  function automatic region_t axis_region(input int unsigned cnt, input int unsigned fp,
                                          input int unsigned sync_len, input int unsigned bp);
    if (cnt < fp) return FP;
    else if (cnt < fp + sync_len) return SYNC;
    else if (cnt < fp + sync_len + bp) return BP;
    else return ACTV;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ov_src_crc16.sv
// Byte-wide CRC-16-CCITT accumulator; clr restarts from CRC16_INIT and may absorb a byte the same cycle.
module ov_src_crc16
  import ov_src_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC16_INIT;
    end else if (clr) begin
      crc <= en ? crc16_byte(CRC16_INIT, din) : CRC16_INIT;
    end else if (en) begin
      crc <= crc16_byte(crc, din);
    end
  end

endmodule

// File: rtl/ov7670_pattern_src.sv
// DVP camera stand-in: hsync/vsync/href/D with programmable timing and test patterns, updated on falling pclk.
// Optional `define OV_SRC_CRC_EN adds a per-frame CRC-16-CCITT of the href bytes (frame_crc/crc_valid).
//
// state   | meaning
// ST_IDLE | counters held at 0, outputs at reset values, waiting for en at a frame boundary
// ST_RUN  | scanning h/v counters through one frame; en/mode re-sampled on the last cycle
module ov7670_pattern_src
  import ov_src_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned BYTES_PER_PIXEL = 2,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 29
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  output logic        hsync,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  D,
  output logic        frame_start,
  output logic [15:0] frame_cnt
`ifdef OV_SRC_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  localparam int unsigned H_ACT0      = H_FP + H_SYNC + H_BP;
  localparam int unsigned V_ACT0      = V_FP + V_SYNC + V_BP;
  localparam int unsigned LINE_LEN    = H_ACT0 + H_ACTIVE * BYTES_PER_PIXEL;
  localparam int unsigned FRAME_LINES = V_ACT0 + V_ACTIVE;

  state_t      state_q, state_nxt;
  mode_t       mode_q, mode_nxt;
  logic [15:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic        frame_done;
  logic        run_nxt, hsync_nxt, vsync_nxt, href_nxt, fs_nxt;
  logic [7:0]  d_nxt;
  region_t     h_rgn, v_rgn;
  logic [31:0] act_byte, pix_x, pix_y, byte_sel, pix;

  always_comb begin
    state_nxt  = state_q;
    mode_nxt   = mode_q;
    h_nxt      = h_cnt;
    v_nxt      = v_cnt;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        h_nxt = '0;
        v_nxt = '0;
        if (en) begin
          state_nxt = ST_RUN;
          mode_nxt  = mode_t'(mode);
        end
      end
      ST_RUN: begin
        if (h_cnt == 16'(LINE_LEN - 1)) begin
          h_nxt = '0;
          if (v_cnt == 16'(FRAME_LINES - 1)) begin
            frame_done = 1'b1;
            v_nxt      = '0;
            if (en) mode_nxt = mode_t'(mode);
            else    state_nxt = ST_IDLE;
          end else begin
            v_nxt = v_cnt + 16'd1;
          end
        end else begin
          h_nxt = h_cnt + 16'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are decoded from the next position so they register together with the counters.
    run_nxt  = (state_nxt == ST_RUN);
    h_rgn    = axis_region(32'(h_nxt), H_FP, H_SYNC, H_BP);
    v_rgn    = axis_region(32'(v_nxt), V_FP, V_SYNC, V_BP);
    act_byte = 32'(h_nxt) - H_ACT0;
    pix_x    = act_byte / BYTES_PER_PIXEL;
    byte_sel = act_byte % BYTES_PER_PIXEL;
    pix_y    = 32'(v_nxt) - V_ACT0;
    case (mode_nxt)
      MODE_HRAMP: pix = pix_x;
      MODE_VRAMP: pix = pix_y;
      MODE_CHECK: pix = (pix_x[3] ^ pix_y[3]) ? '1 : '0;
      default:    pix = '0;
    endcase

    hsync_nxt = !(run_nxt && h_rgn == SYNC);
    vsync_nxt = run_nxt && v_rgn == SYNC;
    href_nxt  = run_nxt && h_rgn == ACTV && v_rgn == ACTV;
    fs_nxt    = run_nxt && v_nxt == 16'(V_FP) && h_nxt == 16'd0;
    d_nxt     = 8'h00;
    if (href_nxt) begin
      d_nxt = (mode_nxt == MODE_BYTECNT) ? act_byte[7:0]
                                         : 8'(pix >> (8 * (BYTES_PER_PIXEL - 1 - byte_sel)));
    end
  end

  always_ff @(negedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_HRAMP;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b0;
      href        <= 1'b0;
      D           <= 8'h00;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_nxt;
      mode_q      <= mode_nxt;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      href        <= href_nxt;
      D           <= d_nxt;
      frame_start <= fs_nxt;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef OV_SRC_CRC_EN
  logic        frame_begin;
  logic [15:0] crc_acc;

  // Accumulator is fed the next byte, so it already holds the whole frame when frame_done fires.
  assign frame_begin = en && (state_q == ST_IDLE || frame_done);

  ov_src_crc16 u_crc (
    .clk   (pclk),
    .rst_n (rst_n),
    .clr   (frame_begin),
    .en    (href_nxt),
    .din   (d_nxt),
    .crc   (crc_acc)
  );

  always_ff @(negedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_crc <= 16'h0000;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= frame_done;
      if (frame_done) frame_crc <= crc_acc;
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_pattern_src.sv
// Randomised bench for ov7670_pattern_src: three small configurations against a frame-position reference model.
module tb_ov7670_pattern_src;

  localparam int N = 3;
  localparam int HA   [N] = '{8, 32, 4};
  localparam int VA   [N] = '{4, 16, 1};
  localparam int BPPS [N] = '{2, 2, 1};
  localparam int HFP = 2, HSY = 3, HBP = 2, VFP = 1, VSY = 1, VBP = 1;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en_r   [N];
  logic [1:0]  mode_r [N];
  logic        hs [N], vs [N], hr [N], fs [N];
  logic [7:0]  dd [N];
  logic [15:0] fc [N];
`ifdef OV_SRC_CRC_EN
  logic [15:0] fcrc [N];
  logic        cv   [N];
`endif

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ov7670_pattern_src #(
      .H_ACTIVE(HA[g]), .V_ACTIVE(VA[g]), .BYTES_PER_PIXEL(BPPS[g]),
      .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) u_dut (
      .pclk        (pclk),
      .rst_n       (rst_n),
      .en          (en_r[g]),
      .mode        (mode_r[g]),
      .hsync       (hs[g]),
      .vsync       (vs[g]),
      .href        (hr[g]),
      .D           (dd[g]),
      .frame_start (fs[g]),
      .frame_cnt   (fc[g])
`ifdef OV_SRC_CRC_EN
      ,
      .frame_crc   (fcrc[g]),
      .crc_valid   (cv[g])
`endif
    );
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int line_len(int id);
    return HFP + HSY + HBP + HA[id] * BPPS[id];
  endfunction

  function automatic int frame_len(int id);
    return line_len(id) * (VFP + VSY + VBP + VA[id]);
  endfunction

  // Expected {hsync, vsync, href, frame_start, D} at a given position in a frame.
  function automatic logic [11:0] exp_sig(int id, bit run, int pos, int md);
    int ll, h, v, b, x, y, k, bpp;
    logic [31:0] p;
    logic hsx, vsx, hrx, fsx;
    logic [7:0] d;
    if (!run) return 12'h800;
    ll  = line_len(id);
    h   = pos % ll;
    v   = pos / ll;
    bpp = BPPS[id];
    hsx = !(h >= HFP && h < HFP + HSY);
    vsx = (v >= VFP && v < VFP + VSY);
    hrx = (h >= HFP + HSY + HBP) && (v >= VFP + VSY + VBP);
    fsx = (v == VFP) && (h == 0);
    d   = 8'h00;
    if (hrx) begin
      b = h - (HFP + HSY + HBP);
      x = b / bpp;
      k = b % bpp;
      y = v - (VFP + VSY + VBP);
      case (md)
        0: p = x;
        1: p = y;
        2: p = (((x / 8) % 2) != ((y / 8) % 2)) ? 32'hFFFF_FFFF : 32'h0;
        default: p = 32'h0;
      endcase
      if (md == 3) d = 8'(b % 256);
      else         d = 8'((p >> (8 * (bpp - 1 - k))) & 32'hFF);
    end
    return {hsx, vsx, hrx, fsx, d};
  endfunction

`ifdef OV_SRC_CRC_EN
  function automatic logic [15:0] crc_ccitt(logic [15:0] c, logic [7:0] d);
    logic fb;
    for (int b = 7; b >= 0; b--) begin
      fb = c[15] ^ d[b];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [15:0] frame_crc_ref(int id, int md);
    logic [15:0] c;
    logic [11:0] s;
    c = 16'hFFFF;
    for (int p = 0; p < frame_len(id); p++) begin
      s = exp_sig(id, 1'b1, p, md);
      if (s[9]) c = crc_ccitt(c, s[7:0]);
    end
    return c;
  endfunction
`endif

  // Reference model: frame position index per configuration, en/mode sampled only at frame boundaries.
  bit          m_run [N];
  int          m_pos [N];
  int          m_md  [N];
  logic [15:0] m_fc  [N];
`ifdef OV_SRC_CRC_EN
  bit          m_done [N];
  logic [15:0] m_crc  [N];
`endif

  always @(negedge pclk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_run[i] = 1'b0;
        m_pos[i] = 0;
        m_md[i]  = 0;
        m_fc[i]  = 16'h0;
`ifdef OV_SRC_CRC_EN
        m_done[i] = 1'b0;
        m_crc[i]  = 16'h0;
`endif
      end else begin
`ifdef OV_SRC_CRC_EN
        m_done[i] = 1'b0;
`endif
        if (!m_run[i]) begin
          if (en_r[i]) begin
            m_run[i] = 1'b1;
            m_pos[i] = 0;
            m_md[i]  = int'(mode_r[i]);
          end
        end else if (m_pos[i] == frame_len(i) - 1) begin
          m_fc[i] = m_fc[i] + 16'd1;
`ifdef OV_SRC_CRC_EN
          m_done[i] = 1'b1;
          m_crc[i]  = frame_crc_ref(i, m_md[i]);
`endif
          m_pos[i] = 0;
          if (en_r[i]) m_md[i] = int'(mode_r[i]);
          else         m_run[i] = 1'b0;
        end else begin
          m_pos[i] = m_pos[i] + 1;
        end
      end
    end
  end

  always @(posedge pclk) begin
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        check_val($sformatf("d%0d_sig", i), 32'({hs[i], vs[i], hr[i], fs[i], dd[i]}),
                  32'(exp_sig(i, m_run[i], m_pos[i], m_md[i])));
        check_val($sformatf("d%0d_fcnt", i), 32'(fc[i]), 32'(m_fc[i]));
`ifdef OV_SRC_CRC_EN
        check_val($sformatf("d%0d_crc_valid", i), 32'(cv[i]), 32'(m_done[i]));
        check_val($sformatf("d%0d_frame_crc", i), 32'(fcrc[i]), 32'(m_crc[i]));
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      en_r[i]   = 1'b0;
      mode_r[i] = 2'd0;
    end
    #1 rst_n = 1'b0;
    #6;
    for (int i = 0; i < N; i++)
      check_val($sformatf("d%0d_reset", i), 32'({hs[i], vs[i], hr[i], fs[i], dd[i], fc[i]}),
                32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000}));
    chk_on = 1'b1;
    @(posedge pclk);
    rst_n = 1'b1;

    // Every mode on every configuration, one long window each.
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < N; i++) begin
        en_r[i]   = 1'b1;
        mode_r[i] = 2'(m);
      end
      repeat (1400) @(posedge pclk);
    end

    // Drop en and change mode mid-frame: frame finishes, then idle.
    for (int i = 0; i < N; i++) begin
      mode_r[i] = 2'($urandom_range(0, 3));
      en_r[i]   = 1'b0;
    end
    repeat (1400) @(posedge pclk);
    #1;
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("d%0d_idle_out", i), 32'({hs[i], vs[i], hr[i], fs[i], dd[i]}), 32'(12'h800));
      check_val($sformatf("d%0d_idle_fcnt", i), 32'(fc[i]), 32'(m_fc[i]));
    end

    // Reset in the middle of an active line of the first configuration.
    for (int i = 0; i < N; i++) en_r[i] = 1'b1;
    for (int c = 0; c < 400 && hr[0] !== 1'b1; c++) @(posedge pclk);
    check_val("href_seen", 32'(hr[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++)
      check_val($sformatf("d%0d_rst_async", i), 32'({hs[i], vs[i], hr[i], fs[i], dd[i], fc[i]}),
                32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000}));
    repeat (3) @(posedge pclk);
    rst_n = 1'b1;

    // Random run/stop requests and mode changes at arbitrary times.
    repeat (6000) begin
      @(posedge pclk);
      for (int i = 0; i < N; i++) begin
        if (en_r[i]) begin
          if ($urandom_range(0, 255) == 0) en_r[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          en_r[i] = 1'b1;
        end
        if ($urandom_range(0, 31) == 0) mode_r[i] = 2'($urandom_range(0, 3));
      end
    end
    @(negedge pclk);
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
